// File: rtl/aes_round_sequencer.sv
// Control FSM that steps the shared AES round datapath through one block (Nr = 10/12/14, encrypt or decrypt).
// Define AES_SEQ_PERF_EN to add the cycle_count_o busy-cycle counter.
module aes_round_sequencer #(
    parameter int OP_W  = 3,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             encrypt_i,
    input  logic [1:0]       key_len_i,
    output logic             op_valid_o,
    output logic [OP_W-1:0]  op_o,
    output logic [3:0]       rk_idx_o,
    input  logic             op_ready_i,
    output logic             busy_o,
    output logic             done_o,
`ifdef AES_SEQ_PERF_EN
    output logic [CNT_W-1:0] cycle_count_o,
`endif
    output logic             err_o
);

    localparam logic [OP_W-1:0] OP_NOP       = OP_W'(0);
    localparam logic [OP_W-1:0] OP_ADDKEY    = OP_W'(1);
    localparam logic [OP_W-1:0] OP_SUB       = OP_W'(2);
    localparam logic [OP_W-1:0] OP_SHIFT     = OP_W'(3);
    localparam logic [OP_W-1:0] OP_MIX       = OP_W'(4);
    localparam logic [OP_W-1:0] OP_INV_SUB   = OP_W'(5);
    localparam logic [OP_W-1:0] OP_INV_SHIFT = OP_W'(6);
    localparam logic [OP_W-1:0] OP_INV_MIX   = OP_W'(7);

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_ROUND, S_FINAL, S_DONE} state_e;

    state_e     state_q, state_d;
    logic       enc_q, enc_d;
    logic [3:0] nr_q, nr_d;
    logic [3:0] round_q, round_d;
    logic [1:0] step_q, step_d;
    logic       err_q, err_d;
    logic [3:0] nr_sel;
    logic       fire;

    assign fire  = op_valid_o & op_ready_i;
    assign err_o = err_q;

    always_comb begin
        case (key_len_i)
            2'b01:   nr_sel = 4'd12;
            2'b10:   nr_sel = 4'd14;
            default: nr_sel = 4'd10;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q <= S_IDLE;
            enc_q   <= 1'b0;
            nr_q    <= 4'd0;
            round_q <= 4'd0;
            step_q  <= 2'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            enc_q   <= enc_d;
            nr_q    <= nr_d;
            round_q <= round_d;
            step_q  <= step_d;
            err_q   <= err_d;
        end
    end

    // round_q doubles as the round-key index, so every ADDKEY simply presents it.
    always_comb begin
        state_d = state_q;
        enc_d   = enc_q;
        nr_d    = nr_q;
        round_d = round_q;
        step_d  = step_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (key_len_i == 2'b11) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = S_PRE;
                        enc_d   = encrypt_i;
                        nr_d    = nr_sel;
                        step_d  = 2'd0;
                        round_d = encrypt_i ? 4'd0 : nr_sel;
                    end
                end
            end
            S_PRE: begin
                if (fire) begin
                    state_d = S_ROUND;
                    step_d  = 2'd0;
                    round_d = enc_q ? 4'd1 : (nr_q - 4'd1);
                end
            end
            S_ROUND: begin
                if (fire) begin
                    step_d = step_q + 2'd1;
                    if (step_q == 2'd3) begin
                        if (enc_q) begin
                            round_d = round_q + 4'd1;
                            if ((round_q + 4'd1) == nr_q) state_d = S_FINAL;
                        end else begin
                            round_d = round_q - 4'd1;
                            if (round_q == 4'd1) state_d = S_FINAL;
                        end
                    end
                end
            end
            S_FINAL: begin
                if (fire) begin
                    step_d = step_q + 2'd1;
                    if (step_q == 2'd2) begin
                        state_d = S_DONE;
                        step_d  = 2'd0;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                round_d = 4'd0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        op_valid_o = 1'b0;
        op_o       = OP_NOP;
        rk_idx_o   = 4'd0;
        busy_o     = 1'b0;
        done_o     = 1'b0;
        case (state_q)
            S_PRE: begin
                op_valid_o = 1'b1;
                busy_o     = 1'b1;
                op_o       = OP_ADDKEY;
                rk_idx_o   = round_q;
            end
            S_ROUND: begin
                op_valid_o = 1'b1;
                busy_o     = 1'b1;
                if (enc_q) begin
                    case (step_q)
                        2'd0:    op_o = OP_SUB;
                        2'd1:    op_o = OP_SHIFT;
                        2'd2:    op_o = OP_MIX;
                        default: begin op_o = OP_ADDKEY; rk_idx_o = round_q; end
                    endcase
                end else begin
                    case (step_q)
                        2'd0:    op_o = OP_INV_SHIFT;
                        2'd1:    op_o = OP_INV_SUB;
                        2'd2:    begin op_o = OP_ADDKEY; rk_idx_o = round_q; end
                        default: op_o = OP_INV_MIX;
                    endcase
                end
            end
            S_FINAL: begin
                op_valid_o = 1'b1;
                busy_o     = 1'b1;
                case (step_q)
                    2'd0:    op_o = enc_q ? OP_SUB : OP_INV_SHIFT;
                    2'd1:    op_o = enc_q ? OP_SHIFT : OP_INV_SUB;
                    2'd2:    begin op_o = OP_ADDKEY; rk_idx_o = round_q; end
                    default: op_o = OP_NOP;
                endcase
            end
            S_DONE: done_o = 1'b1;
            default: ;
        endcase
    end

`ifdef AES_SEQ_PERF_EN
    logic [CNT_W-1:0] count_q;

    // Saturating count of busy cycles; survives done until the next accepted start.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            count_q <= '0;
        end else if (state_q == S_IDLE && start_i && key_len_i != 2'b11) begin
            count_q <= '0;
        end else if (busy_o && count_q != {CNT_W{1'b1}}) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign cycle_count_o = count_q;
`endif

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Scoreboard bench for aes_round_sequencer: stimulus pushes expected operations/done events, a monitor pops and compares.
module tb_aes_round_sequencer;

    localparam int OP_W  = 3;
    localparam int CNT_W = 16;

    localparam int NOP = 0, ADDKEY = 1, SUB = 2, SHIFT = 3, MIX = 4,
                   INV_SUB = 5, INV_SHIFT = 6, INV_MIX = 7;

    logic            clk = 1'b0;
    logic            resetN = 1'b0;
    logic            start = 1'b0;
    logic            encrypt = 1'b1;
    logic [1:0]      keyLen = 2'b00;
    logic            opReady = 1'b1;
    logic            opValid;
    logic [OP_W-1:0] op;
    logic [3:0]      rkIdx;
    logic            busy;
    logic            done;
    logic            err;
`ifdef AES_SEQ_PERF_EN
    logic [CNT_W-1:0] cycleCount;
`endif

    always #5 clk = ~clk;

    aes_round_sequencer #(.OP_W(OP_W), .CNT_W(CNT_W)) dut (
        .clk_i      (clk),
        .reset_i    (resetN),
        .start_i    (start),
        .encrypt_i  (encrypt),
        .key_len_i  (keyLen),
        .op_valid_o (opValid),
        .op_o       (op),
        .rk_idx_o   (rkIdx),
        .op_ready_i (opReady),
        .busy_o     (busy),
        .done_o     (done),
`ifdef AES_SEQ_PERF_EN
        .cycle_count_o (cycleCount),
`endif
        .err_o      (err)
    );

    typedef struct {int opc; int rk;} opItem_t;
    typedef struct {int cyc; int busyCycles; int hs;} doneItem_t;

    opItem_t   expQ[$];
    doneItem_t doneQ[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int hsCount = 0;
    int busyRun = 0;
    bit prevStall = 1'b0;
    int heldOp = 0;
    int heldRk = 0;
    bit stallMode = 1'b0;
    int stallLeft = 0;
    int lastStalledHs = -1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic void pushSeq(input bit enc, input int nr);
        if (enc) begin
            expQ.push_back('{ADDKEY, 0});
            for (int r = 1; r < nr; r++) begin
                expQ.push_back('{SUB, 0});
                expQ.push_back('{SHIFT, 0});
                expQ.push_back('{MIX, 0});
                expQ.push_back('{ADDKEY, r});
            end
            expQ.push_back('{SUB, 0});
            expQ.push_back('{SHIFT, 0});
            expQ.push_back('{ADDKEY, nr});
        end else begin
            expQ.push_back('{ADDKEY, nr});
            for (int r = nr - 1; r >= 1; r--) begin
                expQ.push_back('{INV_SHIFT, 0});
                expQ.push_back('{INV_SUB, 0});
                expQ.push_back('{ADDKEY, r});
                expQ.push_back('{INV_MIX, 0});
            end
            expQ.push_back('{INV_SHIFT, 0});
            expQ.push_back('{INV_SUB, 0});
            expQ.push_back('{ADDKEY, 0});
        end
    endfunction

    always @(posedge clk) cyc = cyc + 1;

    // Ready driver: in stall mode every second operation sees op_ready low for three cycles.
    always @(posedge clk) begin
        #1;
        if (!stallMode) begin
            opReady = 1'b1;
            stallLeft = 0;
        end else if (stallLeft > 0) begin
            stallLeft = stallLeft - 1;
            opReady = (stallLeft == 0);
        end else if (opValid && (hsCount % 2 == 1) && lastStalledHs != hsCount) begin
            lastStalledHs = hsCount;
            stallLeft = 3;
            opReady = 1'b0;
        end else begin
            opReady = 1'b1;
        end
    end

    // Monitor: pops the scoreboard on every handshake and every done pulse.
    always @(negedge clk) begin
        opItem_t   item;
        doneItem_t d;
        if (resetN) begin
            if (busy) busyRun++;
            if (prevStall) begin
                checkOutput("stall_valid", opValid, 1);
                checkOutput("stall_op", op, heldOp);
                checkOutput("stall_rk", rkIdx, heldRk);
            end
            if (opValid && opReady) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_op", op, NOP);
                end else begin
                    item = expQ.pop_front();
                    checkOutput($sformatf("op[%0d]", hsCount), op, item.opc);
                    checkOutput($sformatf("rk[%0d]", hsCount), rkIdx, item.rk);
                end
                hsCount++;
            end
            prevStall = opValid && !opReady;
            heldOp = op;
            heldRk = rkIdx;
            if (done) begin
                checkOutput("done_busy_low", busy, 0);
                checkOutput("done_valid_low", opValid, 0);
                if (doneQ.size() == 0) begin
                    checkOutput("unexpected_done", done, 0);
                end else begin
                    d = doneQ.pop_front();
                    checkOutput("done_hs_count", hsCount, d.hs);
                    if (d.cyc >= 0) checkOutput("done_cycle", cyc, d.cyc);
                    if (d.busyCycles >= 0) begin
                        checkOutput("busy_cycles", busyRun, d.busyCycles);
`ifdef AES_SEQ_PERF_EN
                        checkOutput("cycle_count", cycleCount, d.busyCycles);
`endif
                    end
                end
                busyRun = 0;
            end
        end else begin
            prevStall = 1'b0;
            busyRun = 0;
        end
    end

    // Issues one start at posedge+1 and schedules the expected ops and done event.
    task automatic applyStimulus(input bit enc, input logic [1:0] kl, input bit timed);
        int nr;
        int base;
        int c0;
        nr = (kl == 2'b00) ? 10 : (kl == 2'b01) ? 12 : 14;
        pushSeq(enc, nr);
        base = hsCount;
        start = 1'b1;
        encrypt = enc;
        keyLen = kl;
        @(posedge clk);
        #1;
        start = 1'b0;
        c0 = cyc;
        doneQ.push_back('{timed ? c0 + 4 * nr : -1, timed ? 4 * nr : -1, base + 4 * nr});
    endtask

    task automatic waitIdle(input int budget);
        for (int i = 0; i < budget && doneQ.size() != 0; i++) @(posedge clk);
        #1;
        if (doneQ.size() != 0) begin
            checkOutput("timeout_pending_done", doneQ.size(), 0);
            doneQ.delete();
            expQ.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        int c0;
        $display("[TB] aes_round_sequencer scoreboard bench");

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_valid", opValid, 0);
        checkOutput("rst_op", op, NOP);
        checkOutput("rst_rk", rkIdx, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_err", err, 0);
        @(posedge clk);
        #1;
        resetN = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] encrypt 128");
        applyStimulus(1'b1, 2'b00, 1'b1);
        waitIdle(200);

        $display("[TB] decrypt 256");
        applyStimulus(1'b0, 2'b10, 1'b1);
        waitIdle(200);

        $display("[TB] encrypt 192 with stalls and mid-sequence input changes");
        stallMode = 1'b1;
        applyStimulus(1'b1, 2'b01, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        start = 1'b1;
        encrypt = 1'b0;
        keyLen = 2'b11;
        repeat (4) @(posedge clk);
        #1;
        start = 1'b0;
        keyLen = 2'b00;
        waitIdle(600);
        stallMode = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] reserved key length");
        start = 1'b1;
        encrypt = 1'b1;
        keyLen = 2'b11;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        checkOutput("err_pulse", err, 1);
        checkOutput("err_busy", busy, 0);
        checkOutput("err_valid", opValid, 0);
        checkOutput("err_done", done, 0);
        @(negedge clk);
        checkOutput("err_cleared", err, 0);
        checkOutput("err_busy_after", busy, 0);
        checkOutput("err_valid_after", opValid, 0);
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 2'b00, 1'b1);
        waitIdle(200);

        $display("[TB] reset mid-sequence");
        base = hsCount;
        applyStimulus(1'b1, 2'b00, 1'b0);
        for (int i = 0; i < 200 && hsCount < base + 20; i++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("reset_at_hs", hsCount - base, 20);
        resetN = 1'b0;
        @(posedge clk);
        #1;
        expQ.delete();
        doneQ.delete();
        @(negedge clk);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_valid", opValid, 0);
        checkOutput("midrst_op", op, NOP);
        checkOutput("midrst_rk", rkIdx, 0);
        checkOutput("midrst_done", done, 0);
        @(posedge clk);
        #1;
        resetN = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 2'b00, 1'b1);
        waitIdle(200);

        $display("[TB] start held high across two encrypt-128 blocks");
        pushSeq(1'b1, 10);
        pushSeq(1'b1, 10);
        base = hsCount;
        start = 1'b1;
        encrypt = 1'b1;
        keyLen = 2'b00;
        @(posedge clk);
        #1;
        c0 = cyc;
        doneQ.push_back('{c0 + 40, 40, base + 40});
        doneQ.push_back('{c0 + 82, 40, base + 80});
        repeat (50) @(posedge clk);
        #1;
        start = 1'b0;
        waitIdle(300);

        repeat (5) @(posedge clk);
        #1;
        checkOutput("ops_left", expQ.size(), 0);
        checkOutput("idle_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/aes_round_sequencer.md
Name: aes_round_sequencer

Overview:
- Control FSM that sequences the shared AES round datapath (AddRoundKey, SubBytes, ShiftRows, MixColumns and their inverses) for one 128-bit block.
- Issues one operation at a time with the round-key index. The datapath executes it and acknowledges.
- Handles 128/192/256-bit keys (Nr = 10/12/14) and both encryption and decryption. Sits between the byte-serial input loader and the round datapath.

Parameters:
- OP_W, 3, width of the operation code
- CNT_W, 16, width of the optional performance counter

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- start  in  1  request to process the loaded block; sampled only in IDLE
- encrypt  in  1  1 = encrypt, 0 = decrypt; latched with start
- key_len  in  2  00 = 128, 01 = 192, 10 = 256, 11 = reserved; latched with start
- op_valid  out  1  operation presented to the datapath
- op  out  OP_W  0 NOP, 1 ADDKEY, 2 SUB, 3 SHIFT, 4 MIX, 5 INV_SUB, 6 INV_SHIFT, 7 INV_MIX
- rk_idx  out  4  round-key index for ADDKEY (0..Nr); 0 for other operations
- op_ready  in  1  datapath accepts or completes the current operation
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse: block finished
- err  out  1  one-cycle pulse: start with key_len = 11

Behaviour:
- Reset (reset = 0 at a clk edge):
  - state = IDLE.
  - op_valid, busy, done, err = 0; op = NOP; rk_idx = 0.
  - Internal counters cleared.
  - Reset applies mid-sequence with no completion pulse.
- Handshake:
  - An operation completes on a cycle where op_valid and op_ready are both 1.
  - op and rk_idx stay stable while op_valid = 1 and op_ready = 0.
  - The next operation is presented on the following cycle; there are no bubbles when op_ready stays high.
- Round count: Nr = 10/12/14 from the latched key_len. Round counter is 4 bits, step counter 2 bits (0..3).
- States: IDLE, PRE, ROUND, FINAL, DONE.
  - IDLE:
    - start = 1 and key_len != 11: latch mode and Nr; go to PRE. busy = 1 from the next cycle.
    - start = 1 and key_len = 11: err = 1 for the next cycle; stay IDLE.
    - start = 0: stay IDLE.
  - PRE: present ADDKEY with rk_idx = 0 (encrypt) or Nr (decrypt). On handshake, go to ROUND with round r = 1 (encrypt) or r = Nr-1 (decrypt).
  - ROUND, encrypt: steps SUB, SHIFT, MIX, ADDKEY(r); then r += 1. Go to FINAL when r reaches Nr.
  - ROUND, decrypt: steps INV_SHIFT, INV_SUB, ADDKEY(r), INV_MIX; then r -= 1. Go to FINAL when r reaches 0.
  - FINAL, encrypt: SUB, SHIFT, ADDKEY(Nr).
  - FINAL, decrypt: INV_SHIFT, INV_SUB, ADDKEY(0).
  - After the last FINAL handshake, go to DONE.
  - DONE: done = 1 and busy = 0 for exactly one cycle; op_valid = 0; return to IDLE.
- Total handshakes per block = 4·Nr: 40 / 48 / 56.
- Latency with op_ready held at 1:
  - start sampled at edge T0; operations handshake at T1..T(4·Nr).
  - done pulses in cycle T(4·Nr+1).
- Boundary rules:
  - start while busy is ignored; encrypt and key_len changes mid-sequence are ignored.
  - start in the DONE cycle is ignored; a new start is accepted from IDLE the cycle after.
  - op_ready while op_valid = 0 is ignored.
  - op_ready held low stalls indefinitely with outputs frozen.

Optional Feature:
- Macro: AES_SEQ_PERF_EN.
- When defined:
  - Adds output cycle_count [CNT_W-1:0]. Cleared on start acceptance, +1 on every cycle while busy = 1, saturating at all-ones.
  - Value holds after done until the next accepted start. Reset value is 0.
- When undefined: the port and counter are absent, with no other behavioural change.

Test Plan:
- Encrypt, key_len = 00, op_ready tied 1:
  - op sequence is ADDKEY(0), then {SUB, SHIFT, MIX, ADDKEY(r)} for r = 1..9, then SUB, SHIFT, ADDKEY(10).
  - 40 handshakes; done at T41; busy high T1..T40.
- Decrypt, key_len = 10, op_ready tied 1:
  - op sequence is ADDKEY(14), then {INV_SHIFT, INV_SUB, ADDKEY(r), INV_MIX} for r = 13..1, then INV_SHIFT, INV_SUB, ADDKEY(0).
  - 56 handshakes; with AES_SEQ_PERF_EN, cycle_count = 56 at done.
- Encrypt, key_len = 01, op_ready low 3 cycles on every 2nd operation:
  - op and rk_idx stable during stalls; 48 handshakes; exactly one done pulse.
- start with key_len = 11:
  - err = 1 for one cycle; busy, op_valid and done stay 0.
  - A following valid start (key_len = 00) completes normally.
- reset driven low at handshake 20 of an encrypt-128:
  - Next cycle: busy = 0, op_valid = 0, op = NOP, no done.
  - A fresh start after release produces the full 40-operation sequence.
- start held high continuously through a 128-bit encrypt:
  - The second sequence begins the cycle after the done cycle, with no double-accept during busy.
